uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and parity helper.
// Build option: UART_RX_PARITY_EN adds the PARITY state (start+8+parity+stop frames).
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
`endif

   // Even parity: the parity bit equals the XOR of the data bits.
   function automatic logic parity_even(input logic [UART_DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 1 (line idle).
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, LSB first, mid-bit sampling; returns to IDLE right after the mid-stop sample.
// Build option: UART_RX_PARITY_EN enables an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCKS_PER_BIT = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] data,
   output logic                      valid,
   output logic                      frame_err,
   output logic                      parity_err,
   output logic                      busy
);

   localparam int unsigned CW = $clog2(CLOCKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BIT / 2 - 1);

   logic                      rx_s, rx_prev;
   uart_rx_state_t            state, state_next;
   logic [CW-1:0]             cnt, cnt_next;
   logic [2:0]                bit_idx, bit_next;
   logic [UART_DATA_BITS-1:0] shift, shift_next;
   logic                      valid_next, ferr_next;
`ifdef UART_RX_PARITY_EN
   logic                      par_bad, par_bad_next, perr_next;
`endif

   sync_2ff u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_prev   <= 1'b1;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bit_idx   <= bit_next;
         shift     <= shift_next;
         rx_prev   <= rx_s;
         valid     <= valid_next;
         frame_err <= ferr_next;
         if (valid_next) data <= shift;
`ifdef UART_RX_PARITY_EN
         par_bad    <= par_bad_next;
         parity_err <= perr_next;
`endif
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt + 1'b1;
      bit_next   = bit_idx;
      shift_next = shift;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_next = par_bad;
      perr_next    = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_next = '0;
            bit_next = '0;
            // Only a real 1->0 edge starts a frame, so a stuck-low line stays idle.
            if (!rx_s && rx_prev) state_next = START;
         end
         START: begin
            if (cnt == HALF) begin
               cnt_next   = '0;
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_next   = '0;
               shift_next = {rx_s, shift[UART_DATA_BITS-1:1]};
               bit_next   = bit_idx + 1'b1;
               if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == LAST) begin
               cnt_next     = '0;
               par_bad_next = rx_s ^ parity_even(shift);
               state_next   = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
               ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
               valid_next = rx_s & ~par_bad;
               perr_next  = par_bad;
`else
               valid_next = rx_s;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLOCKS_PER_BIT=10 (parity test only with UART_RX_PARITY_EN).
module tb_uart_rx;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, parity_err, busy;

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int t_start = 0;
   int n_valid = 0, n_ferr = 0, n_perr = 0, n_dbl = 0;
   int v_cyc_last = 0, v_cyc_prev = 0, busy_fall_cyc = 0;
   logic [7:0] v_data_last = '0, v_data_prev = '0;
   logic valid_d = 1'b0, ferr_d = 1'b0, perr_d = 1'b0, busy_d = 1'b0;
`ifdef UART_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
      .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse bookkeeping, sampled on the falling edge.
   always @(negedge clk) begin
      if (valid) begin
         n_valid++;
         v_cyc_prev  = v_cyc_last;
         v_cyc_last  = cyc;
         v_data_prev = v_data_last;
         v_data_last = data;
      end
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if ((valid && valid_d) || (frame_err && ferr_d) || (parity_err && perr_d)) n_dbl++;
      if (busy_d && !busy) busy_fall_cyc = cyc;
      valid_d = valid;
      ferr_d  = frame_err;
      perr_d  = parity_err;
      busy_d  = busy;
   end

   // Called at a falling edge; returns at a falling edge.
   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      t_start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ par_flip);
`endif
      drive_bit(stop);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
      total++; if ({valid, frame_err, parity_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {valid, frame_err, parity_err}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_byte_55;
      int bv, be;
      bv = n_valid; be = n_ferr + n_perr;
      send_frame(8'h55, 1'b1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL u55_count got=%0d exp=1", n_valid - bv); end
      total++; if (v_data_last !== 8'h55) begin bad++; $display("FAIL u55_data got=%h exp=55", v_data_last); end
      total++; if (v_cyc_last - t_start !== 98) begin bad++; $display("FAIL u55_latency got=%0d exp=98", v_cyc_last - t_start); end
      total++; if (busy_fall_cyc !== v_cyc_last) begin bad++; $display("FAIL u55_busy_fall got=%0d exp=%0d", busy_fall_cyc, v_cyc_last); end
      total++; if (n_ferr + n_perr - be !== 0) begin bad++; $display("FAIL u55_errors got=%0d exp=0", n_ferr + n_perr - be); end
   endtask

   task automatic test_back_to_back;
      int bv;
      bv = n_valid;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (n_valid - bv !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n_valid - bv); end
      total++; if (v_data_prev !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", v_data_prev); end
      total++; if (v_data_last !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", v_data_last); end
      total++; if (v_cyc_last - v_cyc_prev !== 100) begin bad++; $display("FAIL b2b_spacing got=%0d exp=100", v_cyc_last - v_cyc_prev); end
   endtask

   task automatic test_glitch;
      int bv, be;
      logic saw_busy;
      bv = n_valid; be = n_ferr + n_perr;
      saw_busy = 1'b0;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", busy); end
      total++; if (n_valid - bv + n_ferr + n_perr - be !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", n_valid - bv + n_ferr + n_perr - be); end
   endtask

   task automatic test_frame_err;
      int bv, bf, bp;
      logic busy_low_line;
      bv = n_valid; bf = n_ferr; bp = n_perr;
      busy_low_line = 1'b0;
      send_frame(8'hA3, 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) busy_low_line = 1'b1;
      end
      total++; if (n_ferr - bf !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - bf); end
      total++; if (n_valid - bv !== 0) begin bad++; $display("FAIL ferr_valid got=%0d exp=0", n_valid - bv); end
      total++; if (n_perr - bp !== 0) begin bad++; $display("FAIL ferr_perr got=%0d exp=0", n_perr - bp); end
      total++; if (data !== 8'hFF) begin bad++; $display("FAIL ferr_data got=%h exp=ff", data); end
      total++; if (busy_low_line !== 1'b0) begin bad++; $display("FAIL ferr_low_line_start got=%b exp=0", busy_low_line); end
      rx = 1'b1;
      repeat (20) @(negedge clk);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int bv, bp, bf;
      bv = n_valid; bp = n_perr; bf = n_ferr;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (n_perr - bp !== 1) begin bad++; $display("FAIL par_bad_count got=%0d exp=1", n_perr - bp); end
      total++; if (n_valid - bv !== 0) begin bad++; $display("FAIL par_bad_valid got=%0d exp=0", n_valid - bv); end
      total++; if (n_ferr - bf !== 0) begin bad++; $display("FAIL par_bad_ferr got=%0d exp=0", n_ferr - bf); end
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL par_ok_count got=%0d exp=1", n_valid - bv); end
      total++; if (v_data_last !== 8'h07) begin bad++; $display("FAIL par_ok_data got=%h exp=07", v_data_last); end
      total++; if (v_cyc_last - t_start !== 108) begin bad++; $display("FAIL par_ok_latency got=%0d exp=108", v_cyc_last - t_start); end
   endtask
`endif

   task automatic test_reset_mid_frame;
      int bv, be;
      logic [7:0] d;
      bv = n_valid; be = n_ferr + n_perr;
      d = 8'h3C;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d[i]);
      rx = d[3];
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      total++; if (data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", data); end
      rst = 1'b0;
      rx  = 1'b1;
      repeat (120) @(negedge clk);
      total++; if (n_valid - bv + n_ferr + n_perr - be !== 0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=0", n_valid - bv + n_ferr + n_perr - be); end
      send_frame(8'h81, 1'b1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL rst81_count got=%0d exp=1", n_valid - bv); end
      total++; if (v_data_last !== 8'h81) begin bad++; $display("FAIL rst81_data got=%h exp=81", v_data_last); end
      total++; if (data !== 8'h81) begin bad++; $display("FAIL rst81_port got=%h exp=81", data); end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_byte_55;
      test_back_to_back;
      test_glitch;
      test_frame_err;
`ifdef UART_RX_PARITY_EN
      test_parity;
`endif
      test_reset_mid_frame;
      total++; if (n_dbl !== 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", n_dbl); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
